apb_uart_master: RTL and testbench
==================================

Name: apb_uart_master

Overview:
- Upstream APB requester that drives apb_uart_top's slave port.
- Converts a simple valid/ready command stream (single read or write) into compliant two-phase APB transfers.
- Returns read data and error status on a valid/ready response channel.
- Adds a wait-state timeout so a hung slave (PREADY stuck low) cannot stall the command source.

Parameters:
- ADDR_W, 4, width of req_addr; zero-extended onto PADDR[31:0].
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort (legal range 1..255).

Ports:
- PCLK  in  1  single clock; all state updates on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  1  command present.
- req_ready  out  1  master can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  register address.
- req_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  read data; 0 for writes and on timeout.
- rsp_err  out  1  PSLVERR sampled high, or timeout.
- rsp_timeout  out  1  abort was caused by timeout.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  32  APB address.
- PWDATA  out  32  APB write data.
- PRDATA  in  33  APB read data; bits [31:0] used, bit 32 ignored.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset (PRESET high, asynchronous): state IDLE. PSELx, PENABLE, PWRITE, rsp_valid, rsp_err and rsp_timeout are 0. PADDR, PWDATA and rsp_rdata are 0. req_ready is 1 once out of reset and stays 0 while PRESET is high.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch write, addr, wdata; go to SETUP.
- SETUP (exactly one cycle):
  - PSELx=1, PENABLE=0; PWRITE, PADDR and PWDATA driven from latched values.
  - Go to ACCESS.
- ACCESS:
  - PSELx=1, PENABLE=1; address, data and direction held stable.
  - On each edge with PREADY=1: capture PRDATA[31:0] (reads only; writes capture 0) and PSLVERR; go to RESP.
  - On each edge with PREADY=0: increment wait counter.
  - When wait counter reaches TIMEOUT: abort. rsp_err=1, rsp_timeout=1, rsp_rdata=0; go to RESP.
- RESP:
  - PSELx=0, PENABLE=0, PWRITE=0; rsp_valid=1 and response fields held stable.
  - On rsp_ready: go to IDLE.
  - No back-to-back transfers: IDLE costs one cycle between transfers.
- Latency: request accepted at edge 0 → SETUP in cycle 1 → ACCESS in cycle 2 → with zero wait states, rsp_valid asserted in cycle 3.
- Wait counter:
  - 8 bits; cleared on entry to SETUP.
  - TIMEOUT=N aborts after N consecutive ACCESS edges with PREADY low.
  - PREADY arriving on the Nth edge wins over the timeout: completion, not abort.
- PADDR is {zeros, req_addr}; PWDATA is driven only from the latch, never combinationally from req_wdata.
- req_ready=0 in SETUP, ACCESS and RESP; req_valid in those states is ignored (not latched).
- A reset mid-transfer drops PSELx and PENABLE asynchronously. The in-flight command is lost and no response is produced.
- PSLVERR is sampled only on the PREADY=1 edge in ACCESS; it is ignored at all other times.

Decomposition:
- Package apb_uart_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP}.
  - typedef apb_req_t {write, addr, wdata}.
  - typedef apb_rsp_t {rdata, err, timeout}.
  - Constant APB_DATA_W=32.
- Sub-module apb_wait_timer: 8-bit counter with clear, enable, and a done output compared against TIMEOUT. Everything else stays in apb_uart_master.

Test Plan:
- Write 0xA5 to addr 0x1 with PREADY tied 1 → SETUP then ACCESS with PADDR=0x1, PWDATA=0xA5, PWRITE=1; rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- Read addr 0x1 with slave returning PRDATA=0x1_0000_00A5 after 3 wait states → rsp_rdata=0x000000A5 (bit 32 dropped); PENABLE high for 4 cycles; rsp_err=0.
- Read with PREADY stuck 0 and TIMEOUT=16 → abort after 16 ACCESS edges; rsp_err=1, rsp_timeout=1, rsp_rdata=0; PSELx low in RESP.
- Write with PSLVERR=1 on the PREADY edge → rsp_err=1, rsp_timeout=0. Then hold rsp_ready=0 for 5 cycles → response stable and req_ready=0 throughout.
- Two req_valid commands back-to-back → the second is accepted only in IDLE after the first rsp handshake; PSELx deasserts for at least 2 cycles between transfers.
- Assert PRESET during ACCESS → PSELx, PENABLE and rsp_valid drop without waiting for a clock edge; after release, req_ready=1 and no stale response appears.

Source files
------------

// File: rtl/apb_uart_pkg.sv
// Shared types and constants for the APB requester that drives apb_uart_top.
package apb_uart_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_mst_state_e;

  // Address is stored already zero-extended to the APB bus width.
  typedef struct packed {
    logic                  write;
    logic [APB_DATA_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } apb_rsp_t;

endpackage

// File: rtl/apb_uart_master_if.sv
// Command/response stream plus APB bus seen by the requester (master) and its environment (slave).
interface apb_uart_master_if
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [APB_DATA_W-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DATA_W-1:0] rsp_rdata;
  logic                  rsp_err;
  logic                  rsp_timeout;
  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_DATA_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W:0]   PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready, PRDATA, PREADY, PSLVERR,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
           PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase; done_o flags that the next low-PREADY edge reaches TIMEOUT.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Clear has priority so a fresh transfer never inherits old wait cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = ((cnt_q + 8'd1) == TIMEOUT[7:0]);
endmodule

// File: rtl/apb_uart_master.sv
// Valid/ready command stream to two-phase APB transfers, with wait-state timeout abort.
module apb_uart_master
  import apb_uart_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input logic PCLK,
  input logic PRESET,
  apb_uart_master_if.master bus
);
  apb_mst_state_e state_q, state_d;
  apb_req_t       req_q, req_d;
  apb_rsp_t       rsp_q, rsp_d;
  logic           ready_q, psel_q, penable_q, pwrite_q, rsp_valid_q;
  logic           tmr_clr_s, tmr_en_s, tmr_done_s;
  logic           unused_prdata_msb;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (PCLK),
    .rst_i (PRESET),
    .clr_i (tmr_clr_s),
    .en_i  (tmr_en_s),
    .done_o(tmr_done_s)
  );

  // Next state, command latch and response capture.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    rsp_d     = rsp_q;
    tmr_clr_s = 1'b0;
    tmr_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid && ready_q) begin
          req_d.write = bus.req_write;
          req_d.addr  = {{(APB_DATA_W-ADDR_W){1'b0}}, bus.req_addr};
          req_d.wdata = bus.req_wdata;
          tmr_clr_s   = 1'b1;
          state_d     = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        tmr_en_s = ~bus.PREADY;
        // A ready slave on the final allowed edge completes rather than aborts.
        if (bus.PREADY) begin
          rsp_d.rdata   = req_q.write ? {APB_DATA_W{1'b0}} : bus.PRDATA[APB_DATA_W-1:0];
          rsp_d.err     = bus.PSLVERR;
          rsp_d.timeout = 1'b0;
          state_d       = RESP;
        end else if (tmr_done_s) begin
          rsp_d   = '{rdata: {APB_DATA_W{1'b0}}, err: 1'b1, timeout: 1'b1};
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the bus pins never glitch.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      req_q       <= '{write: 1'b0, addr: {APB_DATA_W{1'b0}}, wdata: {APB_DATA_W{1'b0}}};
      rsp_q       <= '{rdata: {APB_DATA_W{1'b0}}, err: 1'b0, timeout: 1'b0};
      ready_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_q       <= rsp_d;
      ready_q     <= (state_d == IDLE);
      psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
      penable_q   <= (state_d == ACCESS);
      pwrite_q    <= req_d.write && ((state_d == SETUP) || (state_d == ACCESS));
      rsp_valid_q <= (state_d == RESP);
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.PSELx       = psel_q;
  assign bus.PENABLE     = penable_q;
  assign bus.PWRITE      = pwrite_q;
  assign bus.PADDR       = req_q.addr;
  assign bus.PWDATA      = req_q.wdata;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_q.rdata;
  assign bus.rsp_err     = rsp_q.err;
  assign bus.rsp_timeout = rsp_q.timeout;
  assign unused_prdata_msb = bus.PRDATA[APB_DATA_W];
endmodule

// File: tb/tb_apb_uart_master.sv
// Randomised and directed bench for apb_uart_master against a transaction-level response model.
module tb_apb_uart_master;
  import apb_uart_pkg::*;

  localparam int ADDR_W = 4;
  localparam int TO     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  apb_uart_master_if #(.ADDR_W(ADDR_W)) tif ();

  apb_uart_master #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
    .PCLK  (clk),
    .PRESET(rst),
    .bus   (tif.master)
  );

  typedef struct {
    int          lat;
    int          n_en;
    int          n_setup;
    logic        s_write;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic        acc_unstable;
    logic        ready_seen;
    logic [31:0] rdata;
    logic        err;
    logic        tout;
    logic        rsp_unstable;
    logic        resp_bus_active;
  } obs_t;

  typedef struct {
    int          lat;
    int          n_en;
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } exp_t;

  // Transaction-level expectation: the slave holds PREADY low for 'waits' ACCESS cycles.
  function automatic exp_t model(input logic wr, input int waits, input logic [32:0] prdata,
                                 input logic slverr);
    exp_t e;
    logic [32:0] pr;
    pr = prdata;
    if (waits >= TO) begin
      e.n_en = TO; e.rdata = 32'd0; e.err = 1'b1; e.tout = 1'b1;
    end else begin
      e.n_en = waits + 1; e.rdata = wr ? 32'd0 : pr[31:0]; e.err = slverr; e.tout = 1'b0;
    end
    e.lat = e.n_en + 2;
    return e;
  endfunction

  task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [32:0] prdata, input logic slverr,
                         input int hold, output obs_t o);
    int guard;
    o = '{lat: -1, n_en: 0, n_setup: 0, s_write: 1'b0, s_addr: 32'd0, s_wdata: 32'd0,
          acc_unstable: 1'b0, ready_seen: 1'b0, rdata: 32'd0, err: 1'b0, tout: 1'b0,
          rsp_unstable: 1'b0, resp_bus_active: 1'b0};
    guard = 0;
    while (tif.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL ready_wait req_ready=%b after %0d cycles, required 1", tif.req_ready, guard);
    end
    tif.req_valid = 1'b1; tif.req_write = wr; tif.req_addr = addr; tif.req_wdata = wdata;
    @(posedge clk); #1;
    tif.req_valid = 1'b0;
    tif.req_write = 1'($urandom); tif.req_addr = ADDR_W'($urandom); tif.req_wdata = $urandom;
    for (int c = 1; c < 60; c++) begin
      if (tif.rsp_valid === 1'b1) begin
        o.lat = c;
        break;
      end
      if (tif.req_ready !== 1'b0) o.ready_seen = 1'b1;
      tif.PREADY = 1'b0; tif.PSLVERR = 1'($urandom); tif.PRDATA = 33'({$urandom, $urandom});
      if (tif.PSELx === 1'b1 && tif.PENABLE === 1'b0) begin
        o.n_setup++;
        o.s_write = tif.PWRITE; o.s_addr = tif.PADDR; o.s_wdata = tif.PWDATA;
      end else if (tif.PSELx === 1'b1 && tif.PENABLE === 1'b1) begin
        if (tif.PWRITE !== o.s_write || tif.PADDR !== o.s_addr || tif.PWDATA !== o.s_wdata)
          o.acc_unstable = 1'b1;
        if (o.n_en == waits) begin
          tif.PREADY = 1'b1; tif.PRDATA = prdata; tif.PSLVERR = slverr;
        end
        o.n_en++;
      end
      @(posedge clk); #1;
    end
    tif.PREADY = 1'b0; tif.PSLVERR = 1'b0;
    o.rdata = tif.rsp_rdata; o.err = tif.rsp_err; o.tout = tif.rsp_timeout;
    if ({tif.PSELx, tif.PENABLE, tif.PWRITE} !== 3'b000) o.resp_bus_active = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (tif.rsp_valid !== 1'b1 || tif.rsp_rdata !== o.rdata || tif.rsp_err !== o.err ||
          tif.rsp_timeout !== o.tout) o.rsp_unstable = 1'b1;
      if (tif.req_ready !== 1'b0) o.ready_seen = 1'b1;
      if ({tif.PSELx, tif.PENABLE, tif.PWRITE} !== 3'b000) o.resp_bus_active = 1'b1;
    end
    tif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    tif.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    checks++;
    if (tif.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b exp 0", tif.req_ready);
    end
    checks++;
    if ({tif.PSELx, tif.PENABLE, tif.PWRITE, tif.rsp_valid, tif.rsp_err, tif.rsp_timeout,
         tif.PADDR, tif.PWDATA, tif.rsp_rdata} !== 102'd0) begin
      errors++;
      $display("FAIL reset_outputs psel=%b en=%b wr=%b rv=%b err=%b to=%b paddr=%h pwdata=%h rdata=%h exp all 0",
               tif.PSELx, tif.PENABLE, tif.PWRITE, tif.rsp_valid, tif.rsp_err, tif.rsp_timeout,
               tif.PADDR, tif.PWDATA, tif.rsp_rdata);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (tif.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b exp 1", tif.req_ready);
    end
  endtask

  task automatic test_write_basic();
    obs_t o;
    run_txn(1'b1, 4'h1, 32'h0000_00A5, 0, 33'h1_FFFF_FFFF, 1'b0, 0, o);
    checks++; if (o.lat !== 3) begin errors++; $display("FAIL wr_lat got %0d exp 3", o.lat); end
    checks++; if (o.n_setup !== 1) begin errors++; $display("FAIL wr_setup_cycles got %0d exp 1", o.n_setup); end
    checks++;
    if (o.s_write !== 1'b1 || o.s_addr !== 32'h1 || o.s_wdata !== 32'hA5) begin
      errors++; $display("FAIL wr_setup_bus pwrite=%b paddr=%h pwdata=%h exp 1/00000001/000000a5",
                         o.s_write, o.s_addr, o.s_wdata);
    end
    checks++;
    if (o.rdata !== 32'd0 || o.err !== 1'b0) begin
      errors++; $display("FAIL wr_rsp rdata=%h err=%b exp 0/0", o.rdata, o.err);
    end
    checks++; if (tif.req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_ready got %b exp 1", tif.req_ready); end
  endtask

  task automatic test_read_wait();
    obs_t o;
    run_txn(1'b0, 4'h1, 32'h1234_5678, 3, 33'h1_0000_00A5, 1'b0, 0, o);
    checks++; if (o.n_en !== 4) begin errors++; $display("FAIL rd_penable_cycles got %0d exp 4", o.n_en); end
    checks++; if (o.rdata !== 32'h0000_00A5) begin errors++; $display("FAIL rd_rdata got %h exp 000000a5", o.rdata); end
    checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL rd_err got %b exp 0", o.err); end
    checks++; if (o.acc_unstable !== 1'b0) begin errors++; $display("FAIL rd_access_stable got %b exp 0", o.acc_unstable); end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_txn(1'b0, 4'h1, 32'd0, 1000, 33'h0_DEAD_BEEF, 1'b0, 0, o);
    checks++; if (o.n_en !== TO) begin errors++; $display("FAIL to_access_cycles got %0d exp %0d", o.n_en, TO); end
    checks++;
    if (o.err !== 1'b1 || o.tout !== 1'b1 || o.rdata !== 32'd0) begin
      errors++; $display("FAIL to_rsp err=%b to=%b rdata=%h exp 1/1/0", o.err, o.tout, o.rdata);
    end
    checks++; if (o.resp_bus_active !== 1'b0) begin errors++; $display("FAIL to_psel_in_resp got %b exp 0", o.resp_bus_active); end
    run_txn(1'b0, 4'h9, 32'd0, TO - 1, 33'h0_CAFE_F00D, 1'b0, 0, o);
    checks++;
    if (o.tout !== 1'b0 || o.err !== 1'b0 || o.rdata !== 32'hCAFE_F00D || o.n_en !== TO) begin
      errors++; $display("FAIL to_last_edge_ready to=%b err=%b rdata=%h en=%0d exp 0/0/cafef00d/%0d",
                         o.tout, o.err, o.rdata, o.n_en, TO);
    end
  endtask

  task automatic test_slverr_hold();
    obs_t o;
    run_txn(1'b1, 4'h5, 32'h5555_AAAA, 1, 33'h0_1111_1111, 1'b1, 5, o);
    checks++;
    if (o.err !== 1'b1 || o.tout !== 1'b0 || o.rdata !== 32'd0) begin
      errors++; $display("FAIL slverr_rsp err=%b to=%b rdata=%h exp 1/0/0", o.err, o.tout, o.rdata);
    end
    checks++; if (o.rsp_unstable !== 1'b0) begin errors++; $display("FAIL slverr_hold_stable got %b exp 0", o.rsp_unstable); end
    checks++; if (o.ready_seen !== 1'b0) begin errors++; $display("FAIL slverr_ready_low got %b exp 0", o.ready_seen); end
  endtask

  task automatic test_back_to_back();
    int setups = 0, low_run = 0, gap = -1, rsps = 0;
    logic [31:0] a1 = 32'hFFFF_FFFF, a2 = 32'hFFFF_FFFF, acc_a = 32'hFFFF_FFFF;
    tif.PREADY = 1'b1; tif.PSLVERR = 1'b0; tif.rsp_ready = 1'b1;
    tif.req_valid = 1'b1; tif.req_write = 1'b1; tif.req_addr = 4'h2; tif.req_wdata = 32'hAAAA_0001;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (tif.rsp_valid === 1'b1) rsps++;
      if (tif.PSELx === 1'b1 && tif.PENABLE === 1'b0) begin
        setups++;
        if (setups == 1) begin
          a1 = tif.PADDR;
          tif.req_addr = 4'h7; tif.req_wdata = 32'hBBBB_0002;
        end else begin
          a2 = tif.PADDR; gap = low_run;
          tif.req_valid = 1'b0;
        end
      end else if (tif.PSELx === 1'b1 && setups == 1) begin
        acc_a = tif.PADDR;
      end else if (tif.PSELx !== 1'b1 && setups == 1) begin
        low_run++;
      end
    end
    tif.PREADY = 1'b0; tif.rsp_ready = 1'b0; tif.req_valid = 1'b0;
    checks++; if (setups !== 2) begin errors++; $display("FAIL b2b_transfers got %0d exp 2", setups); end
    checks++;
    if (a1 !== 32'h2 || acc_a !== 32'h2 || a2 !== 32'h7) begin
      errors++; $display("FAIL b2b_addr first=%h access=%h second=%h exp 2/2/7", a1, acc_a, a2);
    end
    checks++; if (gap < 2) begin errors++; $display("FAIL b2b_psel_gap got %0d exp >=2", gap); end
    checks++; if (rsps !== 2) begin errors++; $display("FAIL b2b_responses got %0d exp 2", rsps); end
  endtask

  task automatic test_reset_mid();
    logic stale = 1'b0;
    tif.PREADY = 1'b0;
    tif.req_valid = 1'b1; tif.req_write = 1'b0; tif.req_addr = 4'h3; tif.req_wdata = 32'd0;
    @(posedge clk); #1; tif.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if ({tif.PSELx, tif.PENABLE} !== 2'b11) begin
      errors++; $display("FAIL rstmid_in_access psel/en=%b exp 11", {tif.PSELx, tif.PENABLE});
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({tif.PSELx, tif.PENABLE, tif.rsp_valid, tif.req_ready} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async_drop psel/en/rv/rdy=%b exp 0000",
                         {tif.PSELx, tif.PENABLE, tif.rsp_valid, tif.req_ready});
    end
    @(negedge clk); @(negedge clk); rst = 1'b0; tif.PREADY = 1'b1; tif.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (tif.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", tif.req_ready); end
    for (int c = 0; c < 20; c++) begin
      if (tif.rsp_valid !== 1'b0 || tif.PSELx !== 1'b0) stale = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rstmid_stale_rsp got %b exp 0", stale); end
    tif.PREADY = 1'b0; tif.rsp_ready = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    exp_t e;
    logic        wr, se;
    logic [3:0]  ad;
    logic [31:0] wd;
    logic [32:0] pr;
    int          w, hold;
    for (int i = 0; i < 40; i++) begin
      wr = 1'($urandom); ad = 4'($urandom); wd = $urandom; se = 1'($urandom);
      pr = 33'({$urandom, $urandom}); hold = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       w = 0;
        1:       w = $urandom_range(1, 4);
        2:       w = TO - 1;
        3:       w = TO;
        4:       w = TO + $urandom_range(1, 5);
        default: w = $urandom_range(0, TO + 2);
      endcase
      run_txn(wr, ad, wd, w, pr, se, hold, o);
      e = model(wr, w, pr, se);
      checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL rnd_lat #%0d got %0d exp %0d", i, o.lat, e.lat); end
      checks++; if (o.n_en !== e.n_en) begin errors++; $display("FAIL rnd_access #%0d got %0d exp %0d", i, o.n_en, e.n_en); end
      checks++;
      if (o.n_setup !== 1 || o.s_write !== wr || o.s_addr !== {28'd0, ad} || o.s_wdata !== wd) begin
        errors++; $display("FAIL rnd_setup #%0d n=%0d wr=%b addr=%h wd=%h exp 1/%b/%h/%h",
                           i, o.n_setup, o.s_write, o.s_addr, o.s_wdata, wr, {28'd0, ad}, wd);
      end
      checks++;
      if (o.rdata !== e.rdata || o.err !== e.err || o.tout !== e.tout) begin
        errors++; $display("FAIL rnd_rsp #%0d rdata=%h err=%b to=%b exp %h/%b/%b",
                           i, o.rdata, o.err, o.tout, e.rdata, e.err, e.tout);
      end
      checks++;
      if ({o.acc_unstable, o.ready_seen, o.rsp_unstable, o.resp_bus_active} !== 4'b0000) begin
        errors++; $display("FAIL rnd_protocol #%0d accunst/rdy/rspunst/busact=%b exp 0000", i,
                           {o.acc_unstable, o.ready_seen, o.rsp_unstable, o.resp_bus_active});
      end
      checks++; if (tif.req_ready !== 1'b1) begin errors++; $display("FAIL rnd_idle_ready #%0d got %b exp 1", i, tif.req_ready); end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.req_valid = 1'b0; tif.req_write = 1'b0; tif.req_addr = 4'h0; tif.req_wdata = 32'd0;
    tif.rsp_ready = 1'b0; tif.PRDATA = 33'd0; tif.PREADY = 1'b0; tif.PSLVERR = 1'b0;
    test_reset();
    test_write_basic();
    test_read_wait();
    test_timeout();
    test_slverr_hold();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
